i2s_adc_receiver: RTL and testbench



---
 rtl/audio_pkg.sv | 10 +
 rtl/i2s_adc_receiver_sync_edge.sv | 26 ++
 rtl/i2s_adc_receiver.sv | 140 ++++++++++++++
 tb/tb_i2s_adc_receiver.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and defaults for the codec audio receive path.
package audio_pkg;

  localparam int DATA_WIDTH = 16;

  typedef enum logic [1:0] {IDLE, SKIP, SHIFT, DONE} rx_state_t;

  typedef enum logic {CH_LEFT, CH_RIGHT} chan_t;

endpackage

// File: rtl/i2s_adc_receiver_sync_edge.sv
// Multi-flop synchroniser for one asynchronous codec pin with rise and any-edge detect.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic any_edge_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // No reset here: the chain and history keep tracking the pin through reset,
  // so releasing reset never fabricates an edge from a pin that is already high.
  always_ff @(posedge clk) begin
    sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    hist_q <= sync_q[SYNC_STAGES-1];
  end

  assign q_o        = sync_q[SYNC_STAGES-1];
  assign rise_o     = sync_q[SYNC_STAGES-1] & ~hist_q;
  assign any_edge_o = sync_q[SYNC_STAGES-1] ^ hist_q;

endmodule

// File: rtl/i2s_adc_receiver.sv
// I2S ADC deserialiser: codec-mastered BCLK/LRCK into per-channel valid/ready sample ports.
// state | meaning: IDLE wait first LRCK edge | SKIP one-bit I2S delay | SHIFT capture bits | DONE ignore slot tail
module i2s_adc_receiver #(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  aud_bclk,
  input  logic                  aud_adclrck,
  input  logic                  aud_adcdat,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic                  left_valid,
  input  logic                  left_ready,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  right_valid,
  input  logic                  right_ready,
  output logic                  overrun,
  output logic                  short_frame,
  input  logic                  status_clear
);
  import audio_pkg::*;

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic bclk_rise, lrck_edge, lrck_s, dat_s;
  logic unused_bclk_q, unused_bclk_edge, unused_lrck_rise, unused_dat_rise, unused_dat_edge;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_bclk (
    .clk(clk), .d_i(aud_bclk), .q_o(unused_bclk_q), .rise_o(bclk_rise), .any_edge_o(unused_bclk_edge));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_lrck (
    .clk(clk), .d_i(aud_adclrck), .q_o(lrck_s), .rise_o(unused_lrck_rise), .any_edge_o(lrck_edge));
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_dat (
    .clk(clk), .d_i(aud_adcdat), .q_o(dat_s), .rise_o(unused_dat_rise), .any_edge_o(unused_dat_edge));

  rx_state_t             state_q, state_d;
  chan_t                 chan_q, chan_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, sample;
  logic                  deliver, short_set, ovr_set;

  logic [DATA_WIDTH-1:0] left_data_q, left_data_d, right_data_q, right_data_d;
  logic                  left_valid_q, left_valid_d, right_valid_q, right_valid_d;
  logic                  overrun_q, overrun_d, short_q, short_d;

  always_comb begin
    state_d   = state_q;
    chan_d    = chan_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    deliver   = 1'b0;
    short_set = 1'b0;
    sample    = {shift_q[DATA_WIDTH-2:0], dat_s};
    // An LRCK edge outranks everything; a coincident BCLK rise is the delay slot.
    if (lrck_edge) begin
      chan_d    = lrck_s ? CH_RIGHT : CH_LEFT;
      cnt_d     = '0;
      shift_d   = '0;
      short_set = (state_q == SHIFT);
      state_d   = bclk_rise ? SHIFT : SKIP;
    end else begin
      case (state_q)
        SKIP: if (bclk_rise) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end
        SHIFT: if (bclk_rise) begin
          shift_d = sample;
          if (cnt_q == CNT_W'(DATA_WIDTH-1)) begin
            deliver = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    left_data_d   = left_data_q;
    right_data_d  = right_data_q;
    left_valid_d  = left_valid_q & ~left_ready;
    right_valid_d = right_valid_q & ~right_ready;
    ovr_set       = 1'b0;
    // A held, unaccepted sample wins over the new one.
    if (deliver) begin
      if (chan_q == CH_LEFT) begin
        if (left_valid_q && !left_ready) ovr_set = 1'b1;
        else begin
          left_data_d  = sample;
          left_valid_d = 1'b1;
        end
      end else begin
        if (right_valid_q && !right_ready) ovr_set = 1'b1;
        else begin
          right_data_d  = sample;
          right_valid_d = 1'b1;
        end
      end
    end
    overrun_d = ovr_set | (overrun_q & ~status_clear);
    short_d   = short_set | (short_q & ~status_clear);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      chan_q        <= CH_LEFT;
      cnt_q         <= '0;
      shift_q       <= '0;
      left_data_q   <= '0;
      right_data_q  <= '0;
      left_valid_q  <= 1'b0;
      right_valid_q <= 1'b0;
      overrun_q     <= 1'b0;
      short_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      chan_q        <= chan_d;
      cnt_q         <= cnt_d;
      shift_q       <= shift_d;
      left_data_q   <= left_data_d;
      right_data_q  <= right_data_d;
      left_valid_q  <= left_valid_d;
      right_valid_q <= right_valid_d;
      overrun_q     <= overrun_d;
      short_q       <= short_d;
    end
  end

  assign left_data   = left_data_q;
  assign left_valid  = left_valid_q;
  assign right_data  = right_data_q;
  assign right_valid = right_valid_q;
  assign overrun     = overrun_q;
  assign short_frame = short_q;

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Bench for i2s_adc_receiver: clk-aligned codec model, per-channel scoreboards, a 16-bit and a 24-bit instance.
module tb_i2s_adc_receiver;

  localparam int HALF = 8;  // BCLK half period in clk cycles (~3.1 MHz BCLK, 32-bit slots)

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic reset, status_clear, bclk, lrck, dat, sel24;
  logic left_ready, right_ready;
  logic bclk16, lrck16, dat16, bclk24, lrck24, dat24;

  assign bclk16 = bclk & ~sel24;
  assign lrck16 = lrck & ~sel24;
  assign dat16  = dat & ~sel24;
  assign bclk24 = bclk & sel24;
  assign lrck24 = lrck & sel24;
  assign dat24  = dat & sel24;

  logic [15:0] left_data, right_data;
  logic        left_valid, right_valid, overrun, short_frame;
  logic [23:0] l24_data, r24_data;
  logic        l24_valid, r24_valid, ovr24, short24;

  i2s_adc_receiver #(.DATA_WIDTH(16), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .aud_bclk(bclk16), .aud_adclrck(lrck16), .aud_adcdat(dat16),
    .left_data(left_data), .left_valid(left_valid), .left_ready(left_ready),
    .right_data(right_data), .right_valid(right_valid), .right_ready(right_ready),
    .overrun(overrun), .short_frame(short_frame), .status_clear(status_clear));

  i2s_adc_receiver #(.DATA_WIDTH(24), .SYNC_STAGES(2)) dut24 (
    .clk(clk), .reset(reset), .aud_bclk(bclk24), .aud_adclrck(lrck24), .aud_adcdat(dat24),
    .left_data(l24_data), .left_valid(l24_valid), .left_ready(1'b1),
    .right_data(r24_data), .right_valid(r24_valid), .right_ready(1'b1),
    .overrun(ovr24), .short_frame(short24), .status_clear(status_clear));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_l[$], exp_r[$], exp_l24[$], exp_r24[$];
  event last_bit_ev;

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
  } frame_t;
  frame_t tbl[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got sample %h expected none", name, act);
  endtask

  // Scoreboards pop on every completed valid && ready transfer.
  always @(negedge clk) begin
    if (!reset) begin
      if (left_valid && left_ready) begin
        if (exp_l.size() == 0) unexpected("left_unexpected", 32'(left_data));
        else check("left_data", 32'(left_data), exp_l.pop_front());
      end
      if (right_valid && right_ready) begin
        if (exp_r.size() == 0) unexpected("right_unexpected", 32'(right_data));
        else check("right_data", 32'(right_data), exp_r.pop_front());
      end
      if (l24_valid) begin
        if (exp_l24.size() == 0) unexpected("l24_unexpected", 32'(l24_data));
        else check("l24_data", 32'(l24_data), exp_l24.pop_front());
      end
      if (r24_valid) begin
        if (exp_r24.size() == 0) unexpected("r24_unexpected", 32'(r24_data));
        else check("r24_data", 32'(r24_data), exp_r24.pop_front());
      end
    end
  end

  // One codec slot: LRCK set in BCLK low, rise 0 is the delay bit, rises 1..width carry MSB first.
  // Filler bits are 1 so ignored positions are visible if mis-captured.
  task automatic send_slot(input bit ch, input logic [31:0] word, input int width, input int nrises);
    @(negedge clk);
    lrck = ch;
    for (int k = 0; k < nrises; k++) begin
      dat = (k >= 1 && k <= width) ? word[width-k] : 1'b1;
      repeat (HALF) @(negedge clk);
      bclk = 1'b1;
      if (k == width) -> last_bit_ev;
      repeat (HALF) @(negedge clk);
      bclk = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, 32'(l), 16, 32);
    send_slot(1'b1, 32'(r), 16, 32);
  endtask

  task automatic set_ready_l(input logic v);
    @(posedge clk);
    #2 left_ready = v;
  endtask

  task automatic pulse_clear();
    @(posedge clk);
    #2 status_clear = 1'b1;
    @(posedge clk);
    #2 status_clear = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_left_data"}, 32'(left_data), 32'h0);
    check({tag, "_right_data"}, 32'(right_data), 32'h0);
    check({tag, "_left_valid"}, 32'(left_valid), 32'h0);
    check({tag, "_right_valid"}, 32'(right_valid), 32'h0);
    check({tag, "_overrun"}, 32'(overrun), 32'h0);
    check({tag, "_short_frame"}, 32'(short_frame), 32'h0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{16'hA5C3, 16'h1234};
    tbl[1] = '{16'h8000, 16'h7FFF};
    tbl[2] = '{16'hFFFF, 16'h0000};
    tbl[3] = '{16'h0F0F, 16'hF0F0};

    reset = 1'b1; status_clear = 1'b0; sel24 = 1'b0;
    bclk = 1'b0; lrck = 1'b0; dat = 1'b0;
    left_ready = 1'b1; right_ready = 1'b1;
    repeat (10) @(negedge clk);
    check_reset_outputs("reset");

    // Release reset mid left slot: that partial word must yield nothing.
    exp_r.push_back(32'h5A5A);
    fork
      send_slot(1'b0, 32'hFFFF, 16, 32);
      begin
        repeat (200) @(negedge clk);
        reset = 1'b0;
      end
    join
    send_slot(1'b1, 32'h5A5A, 16, 32);

    foreach (tbl[i]) begin
      exp_l.push_back(32'(tbl[i].l));
      exp_r.push_back(32'(tbl[i].r));
      send_frame(tbl[i].l, tbl[i].r);
    end

    // Overrun: left held unaccepted across two deliveries.
    set_ready_l(1'b0);
    exp_r.push_back(32'h0101);
    exp_r.push_back(32'h0202);
    send_frame(16'h0001, 16'h0101);
    send_frame(16'h0002, 16'h0202);
    @(negedge clk);
    check("ovr_left_data", 32'(left_data), 32'h0001);
    check("ovr_left_valid", 32'(left_valid), 32'h1);
    check("ovr_flag", 32'(overrun), 32'h1);
    check("ovr_right_valid", 32'(right_valid), 32'h0);
    pulse_clear();
    @(negedge clk);
    check("ovr_cleared", 32'(overrun), 32'h0);
    exp_l.push_back(32'h0001);
    set_ready_l(1'b1);
    repeat (2) @(negedge clk);
    check("ovr_drained_valid", 32'(left_valid), 32'h0);

    // Ready pulsed exactly in the delivery cycle of the next left word.
    set_ready_l(1'b0);
    exp_l.push_back(32'h1111);
    exp_r.push_back(32'h0303);
    send_frame(16'h1111, 16'h0303);
    @(negedge clk);
    check("pulse_hold_data", 32'(left_data), 32'h1111);
    exp_l.push_back(32'h2222);
    exp_r.push_back(32'h0404);
    fork
      send_slot(1'b0, 32'h2222, 16, 32);
      begin
        @(last_bit_ev);
        @(posedge clk);
        @(posedge clk);
        #1 left_ready = 1'b1;
        @(posedge clk);
        #1 left_ready = 1'b0;
        check("pulse_valid_cont", 32'(left_valid), 32'h1);
        check("pulse_new_data", 32'(left_data), 32'h2222);
        check("pulse_no_overrun", 32'(overrun), 32'h0);
      end
    join
    send_slot(1'b1, 32'h0404, 16, 32);
    set_ready_l(1'b1);

    // Short frame: LRCK toggles after 10 data bits of a left word.
    exp_r.push_back(32'hBEEF);
    send_slot(1'b0, 32'hDEAD, 16, 11);
    send_slot(1'b1, 32'hBEEF, 16, 32);
    @(negedge clk);
    check("short_flag", 32'(short_frame), 32'h1);

    // Reset in the middle of the right word.
    exp_l.push_back(32'h4321);
    send_slot(1'b0, 32'h4321, 16, 32);
    fork
      send_slot(1'b1, 32'h7777, 16, 32);
      begin
        repeat (200) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("midreset");
        reset = 1'b0;
      end
    join
    exp_l.push_back(32'h1357);
    exp_r.push_back(32'h2468);
    send_frame(16'h1357, 16'h2468);

    repeat (100) @(negedge clk);
    check("left_queue_empty", 32'(exp_l.size()), 32'h0);
    check("right_queue_empty", 32'(exp_r.size()), 32'h0);

    // 24-bit instance: right first to create the LRCK edge, then a full frame.
    lrck = 1'b0;
    repeat (20) @(negedge clk);
    sel24 = 1'b1;
    exp_r24.push_back(32'h123456);
    exp_l24.push_back(32'h0ABCDE);
    exp_r24.push_back(32'h800001);
    send_slot(1'b1, 32'h123456, 24, 32);
    send_slot(1'b0, 32'h0ABCDE, 24, 32);
    send_slot(1'b1, 32'h800001, 24, 32);
    repeat (100) @(negedge clk);
    check("r24_last_data", 32'(r24_data), 32'h800001);
    check("l24_queue_empty", 32'(exp_l24.size()), 32'h0);
    check("r24_queue_empty", 32'(exp_r24.size()), 32'h0);
    check("r24_no_overrun", 32'(ovr24), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
